uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//   Configurable UART transmitter with an AXI-Stream style payload input.
//   Frame: start bit (0), DATA_WIDTH_P data bits LSB first, an optional
//   parity bit, then STOP_BITS_P stop bits (1). Every bit lasts
//   max(prescale,1)*8 clk cycles; prescale is captured with the payload.
//
// Parameters
//   DATA_WIDTH_P  data bits per frame (5..9)
//   PARITY_P      0 none, 1 odd, 2 even
//   STOP_BITS_P   stop bits per frame (1 or 2)
//
// Ports
//   clk            single clock
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   frame payload
//   s_axis_tvalid  payload valid
//   s_axis_tready  payload can be accepted (registered, IDLE only)
//   prescale       bit time in units of 8 clk cycles (0 treated as 1)
//   txd            serial line, idle high (registered)
//   busy           frame in progress (registered)
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int DATA_WIDTH_P = 8,
  parameter int PARITY_P     = 0,
  parameter int STOP_BITS_P  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH_P-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [15:0]             prescale,
  output logic                    txd,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH_P - 1);
  localparam logic [3:0] LAST_STOP_BIT = 4'(STOP_BITS_P - 1);

  // Parity over the payload: even = XOR of data bits, odd = its inverse.
  function automatic logic parity_bit(input logic [DATA_WIDTH_P-1:0] d);
    logic x;
    x = ^d;
    if (PARITY_P == 1) begin
      return ~x;
    end else begin
      return x;
    end
  endfunction

  state_e                  state_q,  state_d;
  logic                    tready_q, tready_d;
  logic                    txd_q,    txd_d;
  logic                    busy_q,   busy_d;
  logic [DATA_WIDTH_P-1:0] shreg_q,  shreg_d;
  logic                    par_q,    par_d;
  // 65535*8 = 524280 cycles per bit needs 19 bits; down-counter never wraps.
  logic [18:0]             period_q, period_d;
  logic [18:0]             cnt_q,    cnt_d;
  // Counts data bits (up to 9) or stop bits within the current state.
  logic [3:0]              bit_q,    bit_d;

  logic [18:0]             eff_period_s;
  logic                    bit_done_s;

  // Bit period for a new frame: prescale of 0 behaves as 1.
  assign eff_period_s = {((prescale == 16'd0) ? 16'd1 : prescale), 3'b000};
  // Last cycle of the current bit.
  assign bit_done_s   = (cnt_q == 19'd0);

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    tready_d = tready_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;

    case (state_q)
      IDLE: begin
        // tready_q is 0 only on the first cycle after reset, so that edge
        // just raises tready and cannot accept a payload.
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (s_axis_tvalid && tready_q) begin
          state_d  = START;
          tready_d = 1'b0;
          txd_d    = 1'b0;
          busy_d   = 1'b1;
          shreg_d  = s_axis_tdata;
          par_d    = parity_bit(s_axis_tdata);
          period_d = eff_period_s;
          cnt_d    = eff_period_s - 19'd1;
          bit_d    = 4'd0;
        end else begin
          tready_d = 1'b1;
        end
      end

      START: begin
        if (bit_done_s) begin
          state_d = DATA;
          txd_d   = shreg_q[0];
          bit_d   = 4'd0;
          cnt_d   = period_q - 19'd1;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      DATA: begin
        if (bit_done_s) begin
          cnt_d = period_q - 19'd1;
          if (bit_q == LAST_DATA_BIT) begin
            bit_d = 4'd0;
            if (PARITY_P != 0) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            // Bit 0 of shreg_q is on the line; bit 1 goes out next.
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      PARITY: begin
        if (bit_done_s) begin
          state_d = STOP;
          txd_d   = 1'b1;
          bit_d   = 4'd0;
          cnt_d   = period_q - 19'd1;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      STOP: begin
        if (bit_done_s) begin
          if (bit_q == LAST_STOP_BIT) begin
            state_d  = IDLE;
            tready_d = 1'b1;
            txd_d    = 1'b1;
            busy_d   = 1'b0;
            bit_d    = 4'd0;
            cnt_d    = 19'd0;
          end else begin
            bit_d = bit_q + 4'd1;
            cnt_d = period_q - 19'd1;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      default: begin
        state_d  = IDLE;
        tready_d = 1'b0;
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        cnt_d    = 19'd0;
        bit_d    = 4'd0;
      end
    endcase
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tready_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      period_q <= 19'd0;
      cnt_q    <= 19'd0;
      bit_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;

endmodule
